// File: rtl/mult_share_arb.sv
// Round-robin arbiter sharing one pipelined 8x8 multiplier among NREQ requesters.
// An in-order tag FIFO remembers the owner of every issued product so results route back.
module mult_share_arb #(
  parameter int NREQ = 4,
  parameter int LAT  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [8*NREQ-1:0] req_a_i,
  input  logic [8*NREQ-1:0] req_b_i,
  output logic [NREQ-1:0]   req_ready_o,
  output logic [NREQ-1:0]   resp_valid_o,
  output logic [15:0]       resp_data_o,
  output logic              mult_en_o,
  output logic [7:0]        mult_a_o,
  output logic [7:0]        mult_b_o,
  input  logic [15:0]       mult_result_i,
  input  logic              mult_result_rdy_i,
  output logic              busy_o,
  output logic              err_o
);
  localparam int DEPTH = LAT + 1;
  localparam int TW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [TW-1:0] LAST_RST = TW'(NREQ - 1);
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_MAX  = PW'(DEPTH - 1);

  logic [TW-1:0] last_grant_q;
  logic [TW-1:0] tag_mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          mult_en_q, err_q;
  logic [7:0]    mult_a_q, mult_b_q;

  logic          can_issue, grant_found, push, pop, fifo_empty;
  logic [TW-1:0] grant_idx, head_tag;
  logic [7:0]    a_arr [NREQ];
  logic [7:0]    b_arr [NREQ];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  assign fifo_empty = (count_q == '0);
  assign can_issue  = (count_q < FULL) | mult_result_rdy_i;
  assign pop        = mult_result_rdy_i & ~fifo_empty;
  assign head_tag   = tag_mem_q[rd_ptr_q];
  assign push       = |(req_valid_i & req_ready_o);

  // Scan from the requester after the last grant, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (int'(last_grant_q) + k) % NREQ;
      if (!grant_found && req_valid_i[idx]) begin
        grant_found = 1'b1;
        grant_idx   = TW'(idx);
      end
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign a_arr[gi]        = req_a_i[8*gi +: 8];
    assign b_arr[gi]        = req_b_i[8*gi +: 8];
    assign req_ready_o[gi]  = rst_n & grant_found & can_issue & (grant_idx == TW'(gi));
    assign resp_valid_o[gi] = pop & (head_tag == TW'(gi));
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem_q[wr_ptr_q] <= grant_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= LAST_RST;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      mult_en_q    <= 1'b0;
      mult_a_q     <= '0;
      mult_b_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      mult_en_q <= push;
      if (push) begin
        mult_a_q     <= a_arr[grant_idx];
        mult_b_q     <= b_arr[grant_idx];
        last_grant_q <= grant_idx;
        wr_ptr_q     <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_d;
      // A strobe with nothing outstanding is dropped and flagged until reset.
      if (mult_result_rdy_i && fifo_empty) err_q <= 1'b1;
    end
  end

  assign resp_data_o = (rst_n & mult_result_rdy_i) ? mult_result_i : 16'd0;
  assign mult_en_o   = mult_en_q;
  assign mult_a_o    = mult_a_q;
  assign mult_b_o    = mult_b_q;
  assign busy_o      = ~fifo_empty;
  assign err_o       = err_q;
endmodule

// File: tb/tb_mult_share_arb.sv
// Directed bench for mult_share_arb with an LAT-deep multiplier model and an owner/product scoreboard.
module tb_mult_share_arb;
  localparam int NREQ  = 4;
  localparam int LAT   = 8;
  localparam int DEPTH = LAT + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [8*NREQ-1:0] req_a = '0, req_b = '0;
  logic [NREQ-1:0]   req_ready, resp_valid;
  logic [15:0]       resp_data, mult_result;
  logic              mult_en, mult_result_rdy, busy, err;
  logic [7:0]        mult_a, mult_b;

  mult_share_arb #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_a_i(req_a), .req_b_i(req_b),
    .req_ready_o(req_ready), .resp_valid_o(resp_valid), .resp_data_o(resp_data),
    .mult_en_o(mult_en), .mult_a_o(mult_a), .mult_b_o(mult_b),
    .mult_result_i(mult_result), .mult_result_rdy_i(mult_result_rdy),
    .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  // Multiplier model: LAT register stages, shares rst_n with the DUT.
  logic [LAT-1:0] pipe_v;
  logic [15:0]    pipe_p [LAT];
  logic           mult_connected = 1'b1, inject = 1'b0;
  logic [15:0]    inj_data = '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v <= '0;
      for (int i = 0; i < LAT; i++) pipe_p[i] <= '0;
    end else begin
      pipe_v    <= {pipe_v[LAT-2:0], mult_en};
      pipe_p[0] <= 16'(mult_a) * 16'(mult_b);
      for (int i = 1; i < LAT; i++) pipe_p[i] <= pipe_p[i-1];
    end
  end

  assign mult_result_rdy = (pipe_v[LAT-1] & mult_connected) | inject;
  assign mult_result     = inject ? inj_data : pipe_p[LAT-1];

  int          n_tests = 0, n_fail = 0;
  int          q_own[$];
  logic [15:0] q_prod[$];
  int          m_last = NREQ - 1;
  logic        m_err = 1'b0, m_en = 1'b0;
  logic [7:0]  m_a = '0, m_b = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock cycle: inputs were set at the preceding negedge; compare, advance model, wait.
  task automatic tick(input string tag);
    logic [NREQ-1:0] exp_rdy, exp_v;
    int g, n;
    bit can_iss;
    #1;
    n = q_own.size();
    check({tag, ".en"}, {31'd0, mult_en}, {31'd0, m_en});
    if (m_en) begin
      check({tag, ".mult_a"}, {24'd0, mult_a}, {24'd0, m_a});
      check({tag, ".mult_b"}, {24'd0, mult_b}, {24'd0, m_b});
    end
    check({tag, ".busy"}, {31'd0, busy}, {31'd0, n != 0});
    check({tag, ".err"}, {31'd0, err}, {31'd0, m_err});
    exp_rdy = '0;
    g = -1;
    can_iss = (n < DEPTH) || mult_result_rdy;
    if (can_iss) begin
      for (int k = 1; k <= NREQ; k++) begin
        int idx;
        idx = (m_last + k) % NREQ;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    check({tag, ".ready"}, {28'd0, req_ready}, {28'd0, exp_rdy});
    if (mult_result_rdy && n != 0) begin
      exp_v = '0;
      exp_v[q_own[0]] = 1'b1;
      check({tag, ".resp_valid"}, {28'd0, resp_valid}, {28'd0, exp_v});
      check({tag, ".resp_data"}, {16'd0, resp_data}, {16'd0, inject ? inj_data : q_prod[0]});
      $display("[TB] resp req=%0d data=%0d", q_own[0], resp_data);
      void'(q_own.pop_front());
      void'(q_prod.pop_front());
    end else begin
      check({tag, ".resp_none"}, {28'd0, resp_valid}, 32'd0);
    end
    if (mult_result_rdy && n == 0) m_err = 1'b1;
    m_en = (g >= 0);
    if (g >= 0) begin
      m_a    = req_a[8*g +: 8];
      m_b    = req_b[8*g +: 8];
      m_last = g;
      q_own.push_back(g);
      q_prod.push_back(16'(m_a) * 16'(m_b));
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".rst_en"}, {31'd0, mult_en}, 32'd0);
    check({tag, ".rst_a"}, {24'd0, mult_a}, 32'd0);
    check({tag, ".rst_b"}, {24'd0, mult_b}, 32'd0);
    check({tag, ".rst_err"}, {31'd0, err}, 32'd0);
    check({tag, ".rst_busy"}, {31'd0, busy}, 32'd0);
    check({tag, ".rst_ready"}, {28'd0, req_ready}, 32'd0);
    check({tag, ".rst_resp_valid"}, {28'd0, resp_valid}, 32'd0);
    check({tag, ".rst_resp_data"}, {16'd0, resp_data}, 32'd0);
  endtask

  // Entered at a negedge; leaves at a negedge with reset released.
  task automatic do_reset(input string tag, input bit keep_valid);
    if (!keep_valid) req_valid = '0;
    inject = 1'b0;
    mult_connected = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs(tag);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    q_own.delete();
    q_prod.delete();
    m_last = NREQ - 1;
    m_err = 1'b0;
    m_en = 1'b0;
  endtask

  initial begin
    int acc, seen;
    @(negedge clk);
    do_reset("init", 1'b0);

    // Single request from requester 1: 3*5 after LAT+1 cycles.
    req_valid = 4'b0010;
    req_a = '0; req_b = '0;
    req_a[15:8] = 8'd3; req_b[15:8] = 8'd5;
    #1 check("single.ready_hand", {28'd0, req_ready}, 32'd2);
    tick("single");
    req_valid = '0;
    for (int c = 1; c <= 12; c++) begin
      #1;
      if (c == 9) begin
        check("single.lat_valid", {28'd0, resp_valid}, 32'd2);
        check("single.lat_data", {16'd0, resp_data}, 32'd15);
        check("single.lat_busy", {31'd0, busy}, 32'd1);
      end else if (c < 9) begin
        check("single.early", {28'd0, resp_valid}, 32'd0);
        check("single.busy_hold", {31'd0, busy}, 32'd1);
      end else begin
        check("single.idle", {31'd0, busy}, 32'd0);
      end
      tick("single");
    end

    // Round-robin fairness with all requesters streaming.
    do_reset("rr", 1'b0);
    req_a = {8'd4, 8'd3, 8'd2, 8'd1};
    req_b = {8'd10, 8'd10, 8'd10, 8'd10};
    req_valid = 4'b1111;
    for (int c = 0; c < 16; c++) begin
      #1 check("rr.rotate", {28'd0, req_ready}, 32'd1 << (c % 4));
      tick("rr");
    end
    req_valid = '0;
    repeat (12) tick("rr_drain");

    // Operand extremes.
    req_valid = 4'b1000;
    req_a[31:24] = 8'd255; req_b[31:24] = 8'd255;
    tick("max");
    req_valid = 4'b0001;
    req_a[7:0] = 8'd0; req_b[7:0] = 8'd200;
    tick("max");
    req_valid = '0;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (resp_valid == 4'b1000) begin
        check("max.ff", {16'd0, resp_data}, 32'd65025);
        seen++;
      end
      if (resp_valid == 4'b0001) begin
        check("max.zero", {16'd0, resp_data}, 32'd0);
        seen++;
      end
      tick("max_drain");
    end
    check("max.seen", seen, 2);

    // Back-pressure with the multiplier disconnected.
    do_reset("bp", 1'b0);
    mult_connected = 1'b0;
    req_a[7:0] = 8'd7; req_b[7:0] = 8'd3;
    req_valid = 4'b0001;
    acc = 0;
    for (int c = 0; c < 14; c++) begin
      #1 if (req_ready[0]) acc++;
      tick("bp");
    end
    check("bp.accepted", acc, 9);
    #1 check("bp.stalled", {28'd0, req_ready}, 32'd0);
    inject = 1'b1;
    inj_data = 16'h1234;
    #1 check("bp.admit", {28'd0, req_ready}, 32'd1);
    check("bp.pop", {28'd0, resp_valid}, 32'd1);
    tick("bp_inject");
    inject = 1'b0;
    #1 check("bp.full_again", {28'd0, req_ready}, 32'd0);
    tick("bp");

    // Spurious strobe with nothing outstanding.
    do_reset("spur", 1'b0);
    inject = 1'b1;
    inj_data = 16'd99;
    #1 check("spur.no_valid", {28'd0, resp_valid}, 32'd0);
    tick("spur");
    inject = 1'b0;
    repeat (3) tick("spur");
    check("spur.sticky", {31'd0, err}, 32'd1);
    do_reset("spur_clear", 1'b0);
    tick("spur_clear");

    // Reset in the middle of a stream, requests kept asserted across it.
    req_a = {8'd4, 8'd3, 8'd2, 8'd1};
    req_b = {8'd10, 8'd10, 8'd10, 8'd10};
    req_valid = 4'b1111;
    repeat (4) tick("mid");
    do_reset("mid", 1'b1);
    #1 check("mid.first_grant", {28'd0, req_ready}, 32'd1);
    repeat (8) tick("mid_run");
    req_valid = '0;
    repeat (12) tick("mid_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
